// File: rtl/half_float_pkg.sv
// Shared half-precision constants, receive-state enum and field slicing
// helper used by the serial link, the deserializer and the divider.
package half_float_pkg;

  localparam int EXP_W        = 5;
  localparam int FRAC_W       = 10;
  localparam int WORD_W       = 1 + EXP_W + FRAC_W;
  localparam int GAP_MAX_DFLT = 8;
  localparam int CNT_W        = $clog2(WORD_W + 1);

  localparam int SIGN_POS = WORD_W - 1;
  localparam int EXP_MSB  = WORD_W - 2;
  localparam int EXP_LSB  = FRAC_W;
  localparam int FRAC_MSB = FRAC_W - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [FRAC_W-1:0] fraction;
  } half_fields_t;

  function automatic half_fields_t split_half(input logic [WORD_W-1:0] word);
    half_fields_t f;
    f.sign     = word[SIGN_POS];
    f.exponent = word[EXP_MSB:EXP_LSB];
    f.fraction = word[FRAC_MSB:0];
    return f;
  endfunction

endpackage

// File: rtl/half_float_classify.sv
// Combinational binary16 class decode: zero, subnormal, infinity, NaN.
module half_float_classify
  import half_float_pkg::*;
(
  input  logic [EXP_W-1:0]  exponent_i,
  input  logic [FRAC_W-1:0] fraction_i,
  output logic              is_zero_o,
  output logic              is_subnormal_o,
  output logic              is_inf_o,
  output logic              is_nan_o
);

  logic exp_zero;
  logic exp_ones;
  logic frac_zero;

  assign exp_zero  = (exponent_i == '0);
  assign exp_ones  = &exponent_i;
  assign frac_zero = (fraction_i == '0);

  assign is_zero_o      = exp_zero &  frac_zero;
  assign is_subnormal_o = exp_zero & ~frac_zero;
  assign is_inf_o       = exp_ones &  frac_zero;
  assign is_nan_o       = exp_ones & ~frac_zero;

endmodule

// File: rtl/half_float_deserializer.sv
// Serial (LSB first) to binary16 receiver with a double-buffered output word.
// HALF_CLASSIFY_EN adds registered is_zero/is_subnormal/is_inf/is_nan outputs.
//
// state | meaning
// IDLE  | waiting for frame_start; stray ser_valid bits are ignored
// SHIFT | collecting frame bits, gap timer running while ser_valid is low
module half_float_deserializer
  import half_float_pkg::*;
#(
  parameter int GAP_MAX = GAP_MAX_DFLT
) (
  input  logic              clk,
  input  logic              res,
  input  logic              frame_start,
  input  logic              ser_in,
  input  logic              ser_valid,
  output logic              sign,
  output logic [EXP_W-1:0]  exponent,
  output logic [FRAC_W-1:0] fraction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_abort,
  output logic              err_overrun,
  input  logic              err_clr
`ifdef HALF_CLASSIFY_EN
  ,
  output logic              is_zero,
  output logic              is_subnormal,
  output logic              is_inf,
  output logic              is_nan
`endif
);

  localparam int GAP_W = $clog2(GAP_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);
  localparam logic [GAP_W-1:0] GAP_FULL = GAP_W'(GAP_MAX);

  rx_state_e           state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [GAP_W-1:0]    gap_q;
  logic [WORD_W-2:0]   shreg_q;
  logic [WORD_W-2:0]   shreg_d;
  logic                busy_q;
  logic                err_abort_q;

  half_fields_t        fields_q;
  half_fields_t        fields_d;
  logic                out_valid_q;
  logic                err_overrun_q;

  logic [WORD_W-1:0]   word_d;
  logic                last_bit;
  logic                load;

  // The register holds the bits still pending; the final bit goes straight
  // into the output word, so the full word exists only in the completion cycle.
  assign shreg_d  = {ser_in, shreg_q[WORD_W-2:1]};
  assign word_d   = {ser_in, shreg_q};
  assign fields_d = split_half(word_d);

  assign last_bit = (state_q == SHIFT) && !frame_start && ser_valid && (cnt_q == CNT_LAST);
  assign load     = last_bit && (!out_valid_q || out_ready);

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      shreg_q     <= '0;
      busy_q      <= 1'b0;
      err_abort_q <= 1'b0;
    end else begin
      err_abort_q <= 1'b0;
      if (frame_start) begin
        state_q     <= SHIFT;
        busy_q      <= 1'b1;
        gap_q       <= '0;
        err_abort_q <= (state_q == SHIFT) && (cnt_q != '0);
        if (ser_valid) begin
          shreg_q <= shreg_d;
          cnt_q   <= CNT_W'(1);
        end else begin
          cnt_q   <= '0;
        end
      end else if (state_q == SHIFT) begin
        if (ser_valid) begin
          shreg_q <= shreg_d;
          gap_q   <= '0;
          if (cnt_q != CNT_FULL) cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end else if (gap_q == GAP_LAST) begin
          gap_q       <= GAP_FULL;
          err_abort_q <= 1'b1;
          state_q     <= IDLE;
          busy_q      <= 1'b0;
        end else if (gap_q != GAP_FULL) begin
          gap_q <= gap_q + 1'b1;
        end
      end
    end
  end

  // A completing frame displaces the held word only if it is being consumed.
  always_ff @(posedge clk) begin
    if (res) begin
      fields_q      <= '0;
      out_valid_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      if (load) begin
        fields_q    <= fields_d;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (last_bit && !load) begin
        err_overrun_q <= 1'b1;
      end else if (err_clr) begin
        err_overrun_q <= 1'b0;
      end
    end
  end

  assign sign        = fields_q.sign;
  assign exponent    = fields_q.exponent;
  assign fraction    = fields_q.fraction;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign err_abort   = err_abort_q;
  assign err_overrun = err_overrun_q;

`ifdef HALF_CLASSIFY_EN
  logic cls_zero_d;
  logic cls_sub_d;
  logic cls_inf_d;
  logic cls_nan_d;
  logic is_zero_q;
  logic is_subnormal_q;
  logic is_inf_q;
  logic is_nan_q;

  half_float_classify u_classify (
    .exponent_i     (fields_d.exponent),
    .fraction_i     (fields_d.fraction),
    .is_zero_o      (cls_zero_d),
    .is_subnormal_o (cls_sub_d),
    .is_inf_o       (cls_inf_d),
    .is_nan_o       (cls_nan_d)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      is_zero_q      <= 1'b0;
      is_subnormal_q <= 1'b0;
      is_inf_q       <= 1'b0;
      is_nan_q       <= 1'b0;
    end else if (load) begin
      is_zero_q      <= cls_zero_d;
      is_subnormal_q <= cls_sub_d;
      is_inf_q       <= cls_inf_d;
      is_nan_q       <= cls_nan_d;
    end
  end

  assign is_zero      = is_zero_q;
  assign is_subnormal = is_subnormal_q;
  assign is_inf       = is_inf_q;
  assign is_nan       = is_nan_q;
`endif

endmodule

// File: tb/tb_half_float_deserializer.sv
// Scoreboard bench for half_float_deserializer: directed scenarios plus
// randomized frames; a monitor pops expected words on every accepted output.
module tb_half_float_deserializer;

  logic        clk = 1'b0;
  logic        res;
  logic        frame_start;
  logic        ser_in;
  logic        ser_valid;
  logic        out_ready;
  logic        err_clr;
  logic        sign;
  logic [4:0]  exponent;
  logic [9:0]  fraction;
  logic        out_valid;
  logic        busy;
  logic        err_abort;
  logic        err_overrun;
`ifdef HALF_CLASSIFY_EN
  logic        is_zero;
  logic        is_subnormal;
  logic        is_inf;
  logic        is_nan;
`endif

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  int          abort_seen = 0;
  int          rdy_mode   = 1;
  bit          force_ready = 1'b0;
  int          hold = 0;
  logic [15:0] mw;
  int          ms, me, mf;
  logic [15:0] w;
  int          base;
  int          n_ab_exp;

  always #5 clk = ~clk;

  half_float_deserializer dut (
    .clk         (clk),
    .res         (res),
    .frame_start (frame_start),
    .ser_in      (ser_in),
    .ser_valid   (ser_valid),
    .sign        (sign),
    .exponent    (exponent),
    .fraction    (fraction),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .err_abort   (err_abort),
    .err_overrun (err_overrun),
    .err_clr     (err_clr)
`ifdef HALF_CLASSIFY_EN
    ,
    .is_zero      (is_zero),
    .is_subnormal (is_subnormal),
    .is_inf       (is_inf),
    .is_nan       (is_nan)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] word, input int n, input int gap, input bit rdy_last);
    for (int i = 0; i < n; i++) begin
      frame_start = (i == 0);
      ser_valid   = 1'b1;
      ser_in      = word[i];
      if (rdy_last && i == n - 1) force_ready = 1'b1;
      step();
      force_ready = 1'b0;
      frame_start = 1'b0;
      ser_valid   = 1'b0;
      if (i < n - 1)
        for (int g = 0; g < gap; g++) step();
    end
  endtask

  task automatic send_word(input logic [15:0] word, input int gap, input bit rdy_last);
    exp_q.push_back(word);
    send_bits(word, 16, gap, rdy_last);
  endtask

  // Consumer: updates out_ready 2 time units after each edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (out_valid && !out_ready) hold++;
      else hold = 0;
      case (rdy_mode)
        0:       out_ready = force_ready;
        1:       out_ready = 1'b1;
        default: out_ready = (hold >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: reference decode is plain arithmetic on the sent word.
  initial begin
    forever begin
      @(negedge clk);
      if (err_abort) abort_seen++;
      if (!res && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %h want none", {sign, exponent, fraction});
        end else begin
          mw = exp_q.pop_front();
          ms = int'(mw) / 32768;
          me = (int'(mw) / 1024) % 32;
          mf = int'(mw) % 1024;
          chk("word_sign", 32'(sign), ms);
          chk("word_exponent", 32'(exponent), me);
          chk("word_fraction", 32'(fraction), mf);
`ifdef HALF_CLASSIFY_EN
          chk("cls_zero", 32'(is_zero), 32'(me == 0 && mf == 0));
          chk("cls_subnormal", 32'(is_subnormal), 32'(me == 0 && mf != 0));
          chk("cls_inf", 32'(is_inf), 32'(me == 31 && mf == 0));
          chk("cls_nan", 32'(is_nan), 32'(me == 31 && mf != 0));
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, want test done");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b1; frame_start = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; err_clr = 1'b0;
    rdy_mode = 1;
    step();
    step();
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_abort", 32'(err_abort), 0);
    chk("reset_overrun", 32'(err_overrun), 0);
    chk("reset_fields", 32'({sign, exponent, fraction}), 0);
    res = 1'b0;
    step();

    // basic frame
    send_word(16'h3C00, 0, 1'b0);
    chk("basic_latency", 32'(out_valid), 1);
    chk("basic_busy_after", 32'(busy), 0);
    repeat (3) step();

    // backpressure and overrun
    rdy_mode = 0;
    send_word(16'hC000, 0, 1'b0);
    send_bits(16'h7C00, 16, 0, 1'b0);
    chk("overrun_set", 32'(err_overrun), 1);
    chk("overrun_held_word", 32'({sign, exponent, fraction}), 32'h0000C000);
    chk("overrun_held_valid", 32'(out_valid), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("overrun_cleared", 32'(err_overrun), 0);
    rdy_mode = 1;
    repeat (3) step();

    // back-to-back with consume in the completion cycle
    rdy_mode = 0;
    send_word(16'h0001, 0, 1'b0);
    repeat (2) step();
    send_word(16'hFE00, 0, 1'b1);
    chk("b2b_no_overrun", 32'(err_overrun), 0);
    chk("b2b_second_word", 32'({sign, exponent, fraction}), 32'h0000FE00);
    rdy_mode = 1;
    repeat (3) step();

    // gap timeout
    base = abort_seen;
    send_bits(16'h5A5A, 7, 0, 1'b0);
    chk("gap_busy_mid", 32'(busy), 1);
    repeat (7) step();
    chk("gap_no_abort_at_7", 32'(err_abort), 0);
    chk("gap_busy_at_7", 32'(busy), 1);
    step();
    chk("gap_abort_pulse", 32'(err_abort), 1);
    chk("gap_busy_cleared", 32'(busy), 0);
    chk("gap_valid_unchanged", 32'(out_valid), 0);
    step();
    chk("gap_abort_one_cycle", 32'(err_abort), 0);
    send_word(16'h3555, 0, 1'b0);
    repeat (3) step();
    chk("gap_abort_count", abort_seen - base, 1);

    // gapped valid bits
    base = abort_seen;
    send_word(16'h1234, 3, 1'b0);
    chk("gapped_latency", 32'(out_valid), 1);
    repeat (3) step();
    chk("gapped_no_abort", abort_seen - base, 0);

    // reset mid-frame with a word held
    rdy_mode = 0;
    send_bits(16'hBEEF, 16, 0, 1'b0);
    send_bits(16'h0F0F, 9, 0, 1'b0);
    res = 1'b1;
    step();
    chk("midreset_valid", 32'(out_valid), 0);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_fields", 32'({sign, exponent, fraction}), 0);
    chk("midreset_overrun", 32'(err_overrun), 0);
    res = 1'b0;
    rdy_mode = 1;
    step();
    send_word(16'h8000, 0, 1'b0);
    repeat (3) step();

    // randomized frames, restarts and idle noise with a bounded-stall consumer
    rdy_mode = 2;
    base = abort_seen;
    n_ab_exp = 0;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        w = 16'($urandom);
        send_bits(w, $urandom_range(1, 15), $urandom_range(0, 3), 1'b0);
        n_ab_exp++;
      end
      w = 16'($urandom);
      send_word(w, $urandom_range(0, 3), 1'b0);
      for (int j = 0; j < int'($urandom_range(0, 4)); j++) begin
        ser_valid = 1'($urandom_range(0, 1));
        ser_in    = 1'($urandom_range(0, 1));
        step();
      end
      ser_valid = 1'b0;
    end
    rdy_mode = 1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) step();
    chk("drain_empty", exp_q.size(), 0);
    chk("random_no_overrun", 32'(err_overrun), 0);
    chk("random_abort_count", abort_seen - base, n_ab_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/half_float_deserializer.md
Name: half_float_deserializer

Overview:
- Receive end of the serial half-precision link: reassembles a 16-bit IEEE-754 binary16 word from a 1-bit stream sent LSB first.
- Presents the decoded sign/exponent/fraction fields to the divider datapath through a valid/ready handshake.
- Double-buffered: a new frame can be received while the previous word waits for the consumer.
- Detects aborted frames, inter-bit gap timeouts and overruns.

Parameters:
- EXP_W, 5, exponent field width.
- FRAC_W, 10, fraction field width; frame length WORD_W = 1+EXP_W+FRAC_W (16).
- GAP_MAX, 8, maximum consecutive cycles with ser_valid low inside a frame before abort.

Ports:
- clk  input  1  clock, all logic on rising edge
- res  input  1  synchronous reset, active-high
- frame_start  input  1  pulse: next valid bit is bit 0 of a new frame
- ser_in  input  1  serial data bit
- ser_valid  input  1  ser_in valid this cycle
- sign  output  1  decoded sign (word bit 15)
- exponent  output  EXP_W  decoded exponent (bits 14:10)
- fraction  output  FRAC_W  decoded fraction (bits 9:0)
- out_valid  output  1  word available
- out_ready  input  1  consumer accepts word
- busy  output  1  frame in progress
- err_abort  output  1  one-cycle pulse: partial frame discarded
- err_overrun  output  1  sticky: completed frame dropped
- err_clr  input  1  clears err_overrun

Behaviour:
- Reset: res=1 sampled at a clk edge gives:
  - state=IDLE, bit counter=0, shift register=0.
  - sign/exponent/fraction=0; out_valid, busy and err_abort=0; err_overrun=0.
  - Reset mid-frame or mid-hold discards everything.
- Receive FSM states: IDLE, SHIFT.
  - IDLE: frame_start -> SHIFT, cnt=0, gap=0. A ser_valid bit in the same cycle as frame_start is taken as bit 0 (cnt=1). ser_valid in IDLE without frame_start is ignored.
  - SHIFT, ser_valid=1: shreg <= {ser_in, shreg[WORD_W-1:1]}, cnt+1, gap=0.
  - SHIFT, ser_valid=0: gap+1. When gap reaches GAP_MAX: err_abort pulse, -> IDLE.
  - SHIFT, frame_start: restarts the frame (cnt=0, or 1 if ser_valid is also high); err_abort pulse if cnt>0.
  - The bit that makes cnt=WORD_W completes the frame: -> IDLE next cycle.
- busy=1 exactly while state=SHIFT (registered).
- Output register:
  - On frame completion the full word is transferred to sign/exponent/fraction and out_valid=1 on the next cycle (1 cycle after the last bit edge).
  - Transfer happens only if out_valid=0, or out_valid=1 and out_ready=1 in the completion cycle (simultaneous consume and load).
  - Otherwise the new word is dropped, err_overrun <= 1, and the held word is unchanged.
- Handshake:
  - out_valid=1 and out_ready=1 with no simultaneous completion: out_valid <= 0 next cycle.
  - Fields are held stable while out_valid=1 and out_ready=0.
  - Fields keep their last value when out_valid=0.
- err_clr: clears err_overrun. If err_clr and a new overrun occur in the same cycle, the overrun wins (stays 1).
- Field mapping: sign=word[WORD_W-1], exponent=word[WORD_W-2:FRAC_W], fraction=word[FRAC_W-1:0].
- cnt width is clog2(WORD_W+1); gap width is clog2(GAP_MAX+1). Neither counter wraps: both saturate at their terminal value.

Optional Feature:
- Macro HALF_CLASSIFY_EN.
- Defined: adds outputs is_zero, is_subnormal, is_inf, is_nan (1 bit each), registered together with the fields and valid under out_valid.
  - is_zero: exp=0 and frac=0.
  - is_subnormal: exp=0 and frac!=0.
  - is_inf: exp all-ones and frac=0.
  - is_nan: exp all-ones and frac!=0.
- Not defined: ports and logic absent; no other behaviour changes.

Decomposition:
- Shared package half_float_pkg holds:
  - EXP_W/FRAC_W/WORD_W constants.
  - Receive-state enum (IDLE, SHIFT).
  - Field-slice constants, reused by the serializer side and the divider.
- One natural sub-module: half_float_classify (combinational field classifier, instantiated only under HALF_CLASSIFY_EN).

Test Plan:
- Basic frame: frame_start, then 16 contiguous valid bits of 0x3C00, LSB first. Expect out_valid=1 one cycle after the last bit; sign=0, exponent=0x0F, fraction=0x000; with the feature, all class flags=0.
- Backpressure and overrun: send 0xC000 with out_ready=0, then 0x7C00. Expect the held word to stay sign=1, exponent=0x10, fraction=0, and err_overrun=1. After err_clr=1 for one cycle, err_overrun=0.
- Back-to-back with consume: send 0x0001 then 0xFE00, with out_ready=1 in the completion cycle of the second frame. Expect no overrun; second word exponent=0x1F, fraction=0x200 (is_nan=1 with the feature).
- Gap timeout: 7 valid bits, then ser_valid=0 for GAP_MAX=8 cycles. Expect an err_abort pulse, busy=0 and out_valid unchanged. A following full 0x3555 frame decodes correctly.
- Gapped valid: 0x1234 sent with ser_valid low for 3 cycles between every bit. Expect a correct decode (sign 0, exponent 0x04, fraction 0x234) and no abort.
- Reset mid-frame: res=1 after 9 bits. Expect all outputs 0 next cycle; a subsequent 0x8000 frame decodes to sign=1, exponent=0, fraction=0.
